// File: rtl/parammod_gray_pkg.sv
// rtl/parammod_gray_pkg.sv - shared types and helpers for the Gray count receive path
package parammod_gray_pkg;

  // Receive-side sequencing: fill the synchronizer, take a first sample, then track changes
  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Gray to binary for widths up to 32; the caller zero-extends narrower values
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Number of set bits; used to spot a synchronized sample that moved more than one bit
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_bin.sv
// rtl/gray_bin.sv - combinational Gray-to-binary decoder
module gray_bin
  import parammod_gray_pkg::*;
#(
  parameter int DATA = 4
) (
  input  logic [DATA-1:0] gray,
  output logic [DATA-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it, built MSB-down
  always_comb begin
    bin = '0;
    bin[DATA-1] = gray[DATA-1];
    for (int i = DATA - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_bin_sync.sv
// rtl/gray_bin_sync.sv - synchronize a Gray count, decode, report updates (optional GRAY_BIN_SYNC_ERRCHK_EN)
module gray_bin_sync
  import parammod_gray_pkg::*;
#(
  parameter int DATA = 4,
  parameter int SYNC = 2
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic [DATA-1:0] in,
  output logic [DATA-1:0] out,
  output logic            upd,
  output logic [DATA-1:0] delta
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
  ,
  output logic            err
`endif
);

  localparam int CW = (SYNC > 1) ? $clog2(SYNC) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DATA-1:0] sync_q [SYNC];
  logic [DATA-1:0] sync_d [SYNC];
  logic [DATA-1:0] g_prev_q, g_prev_d;
  logic [DATA-1:0] out_q, out_d;
  logic [DATA-1:0] delta_q, delta_d;
  logic            upd_q, upd_d;
  logic [DATA-1:0] g;
  logic [DATA-1:0] b;
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
  logic            err_q, err_d;
`endif

  assign g = sync_q[SYNC-1];

  gray_bin #(.DATA(DATA)) u_gray_bin (
    .gray (g),
    .bin  (b)
  );

  // Synchronizer shift and the one-cycle-old copy of its output used for change detection
  always_comb begin
    sync_d[0] = in;
    for (int k = 1; k < SYNC; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    g_prev_d = g;
  end

  // Next-state and next-output logic for INIT/LOAD/RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    upd_d   = 1'b0;
    delta_d = '0;
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      INIT: begin
        // Chain still holds reset zeros until SYNC real samples have shifted in
        out_d = '0;
        if (cnt_q == CW'(SYNC - 1)) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        // First real sample becomes the baseline; no increment is meaningful yet
        out_d   = b;
        upd_d   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (g != g_prev_q) begin
          out_d   = b;
          upd_d   = 1'b1;
          delta_d = b - out_q;
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
          err_d   = (popcount(32'(g ^ g_prev_q)) > 32'd1);
`endif
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
        out_d   = '0;
      end
    endcase
  end

  // State registers; reset discards all history so the next start repeats INIT/LOAD
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      for (int k = 0; k < SYNC; k++) begin
        sync_q[k] <= '0;
      end
      g_prev_q <= '0;
      out_q    <= '0;
      upd_q    <= 1'b0;
      delta_q  <= '0;
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      for (int k = 0; k < SYNC; k++) begin
        sync_q[k] <= sync_d[k];
      end
      g_prev_q <= g_prev_d;
      out_q    <= out_d;
      upd_q    <= upd_d;
      delta_q  <= delta_d;
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign out   = out_q;
  assign upd   = upd_q;
  assign delta = delta_q;
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
  assign err   = err_q;
`endif

endmodule

// File: tb/tb_gray_bin_sync.sv
// tb/tb_gray_bin_sync.sv - self-checking bench for gray_bin_sync (optional GRAY_BIN_SYNC_ERRCHK_EN)
module tb_gray_bin_sync;

  localparam int DATA = 4;
  localparam int SYNC = 2;
  localparam int MOD  = 1 << DATA;

  typedef struct {
    logic [DATA-1:0] g;
    logic [DATA-1:0] b;
    int              n_upd;
    logic [DATA-1:0] d;
  } walk_vec_t;

  logic            clk = 1'b0;
  logic            reset_s = 1'b0;
  logic [DATA-1:0] in_s = '0;
  logic [DATA-1:0] out_s;
  logic            upd_s;
  logic [DATA-1:0] delta_s;
  logic            err_s;

  int checks = 0;
  int failures = 0;

  int              n = 0;
  logic [DATA-1:0] hist [0:2047];
  logic [DATA-1:0] inv [MOD];
  logic [DATA-1:0] m_out = '0;
  int              upd_seen = 0;
  logic [DATA-1:0] last_delta = '0;
  int              upd_ns [$];

  walk_vec_t walk [17];

  always #5 clk = ~clk;

  gray_bin_sync #(.DATA(DATA), .SYNC(SYNC)) dut (
    .clk    (clk),
    .reset_ (reset_s),
    .in     (in_s),
    .out    (out_s),
    .upd    (upd_s),
    .delta  (delta_s)
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
    ,
    .err    (err_s)
`endif
  );

`ifndef GRAY_BIN_SYNC_ERRCHK_EN
  assign err_s = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t n=%0d: got %0d expected %0d", name, $time, n, act, exp);
    end
  endtask

  // One clock with in=v applied ahead of the edge; compares against a timeline model
  task automatic step(input logic [DATA-1:0] v);
    logic [DATA-1:0] e_out, e_delta, gc, gp;
    logic            e_upd, e_err;
    in_s = v;
    @(posedge clk);
    #1;
    n++;
    hist[n] = v;
    e_out = m_out; e_upd = 1'b0; e_delta = '0; e_err = 1'b0;
    if (n <= SYNC) begin
      e_out = '0;
    end else if (n == SYNC + 1) begin
      e_out = inv[hist[1]];
      e_upd = 1'b1;
    end else begin
      gc = hist[n - SYNC];
      gp = hist[n - SYNC - 1];
      if (gc != gp) begin
        e_out   = inv[gc];
        e_upd   = 1'b1;
        e_delta = DATA'((int'(inv[gc]) - int'(m_out) + MOD) % MOD);
        e_err   = ($countones(gc ^ gp) > 1);
      end
    end
    m_out = e_out;
    chk("out", int'(out_s), int'(e_out));
    chk("upd", int'(upd_s), int'(e_upd));
    chk("delta", int'(delta_s), int'(e_delta));
`ifdef GRAY_BIN_SYNC_ERRCHK_EN
    chk("err", int'(err_s), int'(e_err));
`endif
    if (upd_s) begin
      upd_seen++;
      last_delta = delta_s;
      upd_ns.push_back(n);
    end
  endtask

  // Async reset pulse lasting one clock edge, released between edges
  task automatic do_reset(input logic [DATA-1:0] v);
    in_s = v;
    #2;
    reset_s = 1'b0;
    #1;
    chk("rst_out", int'(out_s), 0);
    chk("rst_upd", int'(upd_s), 0);
    chk("rst_delta", int'(delta_s), 0);
    chk("rst_err", int'(err_s), 0);
    @(posedge clk);
    #2;
    reset_s = 1'b1;
    n = 0;
    m_out = '0;
  endtask

  task automatic hold(input logic [DATA-1:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) step(v);
  endtask

  initial begin
    int              base;
    logic [DATA-1:0] cur;
    int              r;

    for (int v = 0; v < MOD; v++) inv[DATA'(v ^ (v >> 1))] = DATA'(v);
    for (int i = 0; i < 17; i++) begin
      walk[i].g     = DATA'((i % MOD) ^ ((i % MOD) >> 1));
      walk[i].b     = DATA'(i % MOD);
      walk[i].n_upd = (i == 0) ? 0 : 1;
      walk[i].d     = (i == 0) ? DATA'(0) : DATA'(1);
    end

    #12;
    // Reset with in=0: single LOAD pulse, then silence
    do_reset(4'b0000);
    base = upd_seen;
    hold(4'b0000, SYNC + 8);
    chk("load_upd_count_zero", upd_seen - base, 1);
    chk("load_at_n", upd_ns[upd_ns.size() - 1], SYNC + 1);

    // Reset with in held at gray 1000 (binary 15)
    do_reset(4'b1000);
    hold(4'b1000, SYNC + 1);
    chk("load15_out", int'(out_s), 15);
    chk("load15_delta", int'(delta_s), 0);
    chk("load15_err", int'(err_s), 0);
    hold(4'b1000, 3);

    // Gray walk 0..15,0 one step every 3 cycles
    do_reset(4'b0000);
    hold(4'b0000, SYNC + 3);
    for (int i = 0; i < 17; i++) begin
      base = upd_seen;
      hold(walk[i].g, 3);
      chk("walk_out", int'(out_s), int'(walk[i].b));
      chk("walk_upd_count", upd_seen - base, walk[i].n_upd);
      if (walk[i].n_upd != 0) chk("walk_delta", int'(last_delta), int'(walk[i].d));
    end

    // Back-to-back Gray steps 0011 -> 0010 -> 0110
    do_reset(4'b0011);
    hold(4'b0011, SYNC + 3);
    upd_ns.delete();
    step(4'b0010);
    step(4'b0110);
    hold(4'b0110, 4);
    chk("b2b_count", upd_ns.size(), 2);
    if (upd_ns.size() == 2) chk("b2b_adjacent", upd_ns[1] - upd_ns[0], 1);
    chk("b2b_out", int'(out_s), 4);

    // Multi-bit jump 0000 -> 0101 (binary 6)
    do_reset(4'b0000);
    hold(4'b0000, SYNC + 3);
    base = upd_seen;
    step(4'b0101);
    hold(4'b0101, SYNC + 2);
    chk("jump_upd_count", upd_seen - base, 1);
    chk("jump_out", int'(out_s), 6);
    chk("jump_delta", int'(last_delta), 6);

    // Reset mid-walk at out=9; LOAD must report 9 with delta 0
    do_reset(4'b0000);
    hold(4'b0000, SYNC + 3);
    for (int v = 1; v <= 9; v++) hold(DATA'(v ^ (v >> 1)), 3);
    chk("mid_out9", int'(out_s), 9);
    do_reset(DATA'(9 ^ (9 >> 1)));
    upd_ns.delete();
    hold(DATA'(9 ^ (9 >> 1)), SYNC + 4);
    chk("mid_reload_out", int'(out_s), 9);
    chk("mid_reload_count", upd_ns.size(), 1);

    // Random activity: mostly single-bit Gray steps, occasional arbitrary jumps
    do_reset(4'b0000);
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        cur = cur;
      end else if (r < 9) begin
        cur = cur ^ DATA'(1 << $urandom_range(0, DATA - 1));
      end else begin
        cur = DATA'($urandom_range(0, MOD - 1));
      end
      step(cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
